act7_tdm_demux_1by4: RTL

ACT7_TDM_DEMUX_1BY4 -- requirements
Module: act7_tdm_demux_1by4

---
 rtl/act7_tdm_demux_1by4.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/act7_tdm_demux_1by4.sv
// act7_tdm_demux_1by4: 1-to-4 time-division demultiplexer.
// A sync-marked valid beat is slot 0 (channel y0). Each following valid beat
// fills the next channel in order. A frame is complete when y3 is captured
// after y0..y2 of the same frame. Out-of-order sync is a framing error.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  HUNT  | not aligned; ignore beats until a sync beat arrives
//  RUN   | aligned; slot_q names the channel the next beat belongs to
module act7_tdm_demux_1by4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       ch_valid,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [3:0]       cap_d;
  logic [3:0]       ch_valid_q;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             locked_q;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;

  // Next-state, capture enables and event pulses for the current beat.
  // Reaching slot 3 in RUN is only possible through y0, y1, y2 of the same
  // frame (every entry into RUN and every resync lands on slot 1 after a y0
  // capture), so a y3 capture always closes an in-order frame.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cap_d         = 4'b0000;
    sync_err_d    = 1'b0;
    frame_valid_d = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            cap_d   = 4'b0001;
            slot_d  = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // Sync on slot 0 is a normal frame start; anywhere else it
            // abandons the partial frame and realigns on this beat.
            cap_d      = 4'b0001;
            slot_d     = 2'd1;
            sync_err_d = (slot_q != 2'd0);
          end else if (slot_q == 2'd0) begin
            sync_err_d = 1'b1;
            slot_d     = 2'd0;
            state_d    = HUNT;
          end else begin
            cap_d         = 4'b0001 << slot_q;
            slot_d        = slot_q + 2'd1;
            frame_valid_d = (slot_q == 2'd3);
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  // Completed-frame counter, wraps naturally at 8 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_valid_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Alignment state, slot pointer, lock indicator and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      locked_q    <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      locked_q    <= (state_d == RUN);
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // One-cycle event strobes; all zero on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_valid_q    <= 4'b0000;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      ch_valid_q    <= cap_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Channel registers: only the addressed channel loads, the rest hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
    end else begin
      if (cap_d[0]) y0_q <= din;
      if (cap_d[1]) y1_q <= din;
      if (cap_d[2]) y2_q <= din;
      if (cap_d[3]) y3_q <= din;
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign ch_valid    = ch_valid_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
